// File: rtl/exc_commit_ctrl.sv
// Exception / interrupt / ERTN commit controller: accepts one WB event at a time,
// pulses the CSR commit strobe, flushes the pipe and holds a fetch redirect until accepted.
module exc_commit_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic             wb_ex_in,
    input  logic             wb_ertn,
    input  logic [5:0]       wb_ecode_in,
    input  logic [8:0]       wb_esubcode_in,
    input  logic [31:0]      wb_pc_in,
    input  logic [31:0]      wb_vaddr_in,
    input  logic             has_int,
    input  logic [31:0]      ex_entry,
    input  logic [31:0]      ertn_entry,
    input  logic             redirect_ready,
    output logic             wb_ex,
    output logic             ertn_flush,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_vaddr,
    output logic             pipe_flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] ex_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t state_r;
    logic   is_ertn_r;
    logic   event_s;

    assign event_s = wb_valid & (has_int | wb_ex_in | wb_ertn);

    // Commit sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            is_ertn_r      <= 1'b0;
            wb_ex          <= 1'b0;
            ertn_flush     <= 1'b0;
            wb_ecode       <= 6'h00;
            wb_esubcode    <= 9'h000;
            wb_pc          <= 32'h0000_0000;
            wb_vaddr       <= 32'h0000_0000;
            pipe_flush     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0000_0000;
            busy           <= 1'b0;
            ex_count       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (event_s) begin
                        state_r    <= COMMIT;
                        busy       <= 1'b1;
                        pipe_flush <= 1'b1;
                        if (has_int) begin
                            is_ertn_r   <= 1'b0;
                            wb_ex       <= 1'b1;
                            wb_ecode    <= 6'h00;
                            wb_esubcode <= 9'h000;
                            wb_pc       <= wb_pc_in;
                            wb_vaddr    <= wb_vaddr_in;
                        end else if (wb_ex_in) begin
                            is_ertn_r   <= 1'b0;
                            wb_ex       <= 1'b1;
                            wb_ecode    <= wb_ecode_in;
                            wb_esubcode <= wb_esubcode_in;
                            wb_pc       <= wb_pc_in;
                            wb_vaddr    <= wb_vaddr_in;
                        end else begin
                            // ERTN carries no event fields; CSR-facing fields keep their last values.
                            is_ertn_r  <= 1'b1;
                            ertn_flush <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    wb_ex          <= 1'b0;
                    ertn_flush     <= 1'b0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= is_ertn_r ? ertn_entry : ex_entry;
                    state_r        <= REDIRECT;
                    if (!is_ertn_r && (ex_count != {CNT_W{1'b1}})) begin
                        ex_count <= ex_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                REDIRECT: begin
                    if (redirect_valid && redirect_ready) begin
                        state_r        <= IDLE;
                        redirect_valid <= 1'b0;
                        pipe_flush     <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    wb_ex          <= 1'b0;
                    ertn_flush     <= 1'b0;
                    pipe_flush     <= 1'b0;
                    redirect_valid <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: vector table through a scoreboard queue,
// plus hand sequences for backpressure, busy masking, reset abort and saturation.
module tb_exc_commit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_ex_in, wb_ertn, has_int, redirect_ready;
    logic [5:0]  wb_ecode_in;
    logic [8:0]  wb_esubcode_in;
    logic [31:0] wb_pc_in, wb_vaddr_in, ex_entry, ertn_entry;
    logic        wb_ex, ertn_flush, pipe_flush, redirect_valid, busy;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr, redirect_pc;
    logic [15:0] ex_count;

    logic        s_wb_ex, s_ertn_flush, s_pipe_flush, s_redirect_valid, s_busy;
    logic [5:0]  s_wb_ecode;
    logic [8:0]  s_wb_esubcode;
    logic [31:0] s_wb_pc, s_wb_vaddr, s_redirect_pc;
    logic [1:0]  s_ex_count;

    always #5 clk = ~clk;

    exc_commit_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ex_in(wb_ex_in), .wb_ertn(wb_ertn),
        .wb_ecode_in(wb_ecode_in), .wb_esubcode_in(wb_esubcode_in), .wb_pc_in(wb_pc_in),
        .wb_vaddr_in(wb_vaddr_in), .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .redirect_ready(redirect_ready), .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .pipe_flush(pipe_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy), .ex_count(ex_count)
    );

    exc_commit_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ex_in(wb_ex_in), .wb_ertn(wb_ertn),
        .wb_ecode_in(wb_ecode_in), .wb_esubcode_in(wb_esubcode_in), .wb_pc_in(wb_pc_in),
        .wb_vaddr_in(wb_vaddr_in), .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .redirect_ready(redirect_ready), .wb_ex(s_wb_ex), .ertn_flush(s_ertn_flush), .wb_ecode(s_wb_ecode),
        .wb_esubcode(s_wb_esubcode), .wb_pc(s_wb_pc), .wb_vaddr(s_wb_vaddr), .pipe_flush(s_pipe_flush),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .busy(s_busy), .ex_count(s_ex_count)
    );

    typedef struct {
        logic        vld, intr, ex, ertn;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] pc, va, eentry, era;
        logic        exp_ev, exp_ex;
        logic [5:0]  exp_ecode;
        logic [8:0]  exp_esub;
        logic [31:0] exp_pc, exp_va, exp_rpc;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];
    vec_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        wb_valid = 1'b0; wb_ex_in = 1'b0; wb_ertn = 1'b0; has_int = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        wb_valid = v.vld; has_int = v.intr; wb_ex_in = v.ex; wb_ertn = v.ertn;
        wb_ecode_in = v.ecode; wb_esubcode_in = v.esub; wb_pc_in = v.pc; wb_vaddr_in = v.va;
        ex_entry = v.eentry; ertn_entry = v.era;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        int   n;
        drive(v);
        redirect_ready = 1'b1;
        if (v.exp_ev) sb_q.push_back(v);
        step();
        clear_ev();
        if (!v.exp_ev) begin
            chk($sformatf("v%0d no_event_busy", idx), busy, 1'b0);
            chk($sformatf("v%0d no_event_pulse", idx), wb_ex | ertn_flush, 1'b0);
        end else begin
            n = 0;
            while (!(wb_ex | ertn_flush) && n < 4) begin
                step();
                n++;
            end
            chk($sformatf("v%0d commit_seen", idx), wb_ex | ertn_flush, 1'b1);
            e = sb_q.pop_front();
            chk($sformatf("v%0d commit_latency", idx), n, 0);
            chk($sformatf("v%0d wb_ex", idx), wb_ex, e.exp_ex);
            chk($sformatf("v%0d ertn_flush", idx), ertn_flush, !e.exp_ex);
            chk($sformatf("v%0d ecode", idx), wb_ecode, e.exp_ecode);
            chk($sformatf("v%0d esubcode", idx), wb_esubcode, e.exp_esub);
            chk($sformatf("v%0d pc", idx), wb_pc, e.exp_pc);
            chk($sformatf("v%0d vaddr", idx), wb_vaddr, e.exp_va);
            chk($sformatf("v%0d flush_commit", idx), {pipe_flush, busy}, 2'b11);
            step();
            chk($sformatf("v%0d redirect_valid", idx), redirect_valid, 1'b1);
            chk($sformatf("v%0d redirect_pc", idx), redirect_pc, e.exp_rpc);
            chk($sformatf("v%0d pulse_gone", idx), wb_ex | ertn_flush, 1'b0);
            chk($sformatf("v%0d ex_count", idx), ex_count, e.exp_cnt);
            step();
            chk($sformatf("v%0d idle", idx), {busy, redirect_valid, pipe_flush}, 3'b000);
        end
    endtask

    function automatic vec_t mk(input logic vld, intr, ex, ertn, input logic [5:0] ec, input logic [8:0] es,
                                input logic [31:0] pc, va, een, era, input logic xev, xex,
                                input logic [5:0] xec, input logic [8:0] xes,
                                input logic [31:0] xpc, xva, xrpc, input logic [15:0] xcnt);
        vec_t v;
        v.vld = vld; v.intr = intr; v.ex = ex; v.ertn = ertn; v.ecode = ec; v.esub = es;
        v.pc = pc; v.va = va; v.eentry = een; v.era = era; v.exp_ev = xev; v.exp_ex = xex;
        v.exp_ecode = xec; v.exp_esub = xes; v.exp_pc = xpc; v.exp_va = xva; v.exp_rpc = xrpc;
        v.exp_cnt = xcnt;
        return v;
    endfunction

    initial begin
        vec_t v;
        vecs[0] = mk(1'b1, 1'b0, 1'b1, 1'b0, 6'h09, 9'h000, 32'h1C00_0010, 32'h1C00_0003, 32'h1C00_8000, 32'h1C00_0040,
                     1'b1, 1'b1, 6'h09, 9'h000, 32'h1C00_0010, 32'h1C00_0003, 32'h1C00_8000, 16'd1);
        vecs[1] = mk(1'b1, 1'b1, 1'b1, 1'b1, 6'h15, 9'h01A, 32'h1C00_0020, 32'h1C00_00F0, 32'h1C00_8000, 32'h1C00_0040,
                     1'b1, 1'b1, 6'h00, 9'h000, 32'h1C00_0020, 32'h1C00_00F0, 32'h1C00_8000, 16'd2);
        vecs[2] = mk(1'b1, 1'b0, 1'b0, 1'b1, 6'h03, 9'h005, 32'h1C00_0030, 32'h1234_5678, 32'h1C00_8000, 32'h1C00_0040,
                     1'b1, 1'b0, 6'h00, 9'h000, 32'h1C00_0020, 32'h1C00_00F0, 32'h1C00_0040, 16'd2);
        vecs[3] = mk(1'b1, 1'b0, 1'b1, 1'b0, 6'h3F, 9'h1FF, 32'h1C00_0100, 32'hDEAD_BEEC, 32'h1C00_C000, 32'h1C00_0040,
                     1'b1, 1'b1, 6'h3F, 9'h1FF, 32'h1C00_0100, 32'hDEAD_BEEC, 32'h1C00_C000, 16'd3);
        vecs[4] = mk(1'b0, 1'b1, 1'b1, 1'b0, 6'h01, 9'h000, 32'h1C00_0200, 32'h0, 32'h1C00_8000, 32'h1C00_0040,
                     1'b0, 1'b0, 6'h00, 9'h000, 32'h0, 32'h0, 32'h0, 16'd3);
        vecs[5] = mk(1'b1, 1'b0, 1'b0, 1'b0, 6'h01, 9'h000, 32'h1C00_0200, 32'h0, 32'h1C00_8000, 32'h1C00_0040,
                     1'b0, 1'b0, 6'h00, 9'h000, 32'h0, 32'h0, 32'h0, 16'd3);
        vecs[6] = mk(1'b1, 1'b1, 1'b0, 1'b0, 6'h0A, 9'h003, 32'h1C00_0200, 32'h0000_0000, 32'h1C00_8000, 32'h1C00_0040,
                     1'b1, 1'b1, 6'h00, 9'h000, 32'h1C00_0200, 32'h0000_0000, 32'h1C00_8000, 16'd4);

        clear_ev();
        wb_ecode_in = 6'h00; wb_esubcode_in = 9'h000; wb_pc_in = 32'h0; wb_vaddr_in = 32'h0;
        ex_entry = 32'h0; ertn_entry = 32'h0; redirect_ready = 1'b1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        chk("reset_ctrl", {wb_ex, ertn_flush, pipe_flush, redirect_valid, busy}, 5'b00000);
        chk("reset_fields", {wb_ecode, wb_esubcode, wb_pc, wb_vaddr}, 79'h0);
        chk("reset_rpc_cnt", {redirect_pc, ex_count}, 48'h0);
        step();
        chk("idle_ready_ignored", busy, 1'b0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // ERTN with five cycles of redirect backpressure
        v = mk(1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 9'h000, 32'h1C00_0300, 32'h0, 32'h1C00_8000, 32'h1C00_0040,
               1'b0, 1'b0, 6'h00, 9'h000, 32'h0, 32'h0, 32'h0, 16'd0);
        drive(v);
        redirect_ready = 1'b0;
        step(); clear_ev();
        chk("bp_commit", {ertn_flush, wb_ex, pipe_flush}, 3'b101);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {redirect_valid, pipe_flush, busy}, 3'b111);
            chk($sformatf("bp_pc%0d", i), redirect_pc, 32'h1C00_0040);
            step();
        end
        chk("bp_still_held", redirect_valid, 1'b1);
        redirect_ready = 1'b1;
        step();
        chk("bp_release", {busy, redirect_valid, pipe_flush}, 3'b000);
        chk("bp_count", ex_count, 16'd4);

        // events raised while busy are dropped
        v = mk(1'b1, 1'b0, 1'b1, 1'b0, 6'h07, 9'h000, 32'h1C00_0400, 32'h0, 32'h1C00_8000, 32'h1C00_0040,
               1'b0, 1'b0, 6'h00, 9'h000, 32'h0, 32'h0, 32'h0, 16'd0);
        drive(v);
        redirect_ready = 1'b0;
        step();
        chk("mask_first_pulse", wb_ex, 1'b1);
        step();
        wb_valid = 1'b1; wb_ex_in = 1'b1; has_int = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mask_nopulse%0d", i), {wb_ex, busy}, 2'b01);
            step();
        end
        redirect_ready = 1'b1;
        clear_ev();
        step();
        chk("mask_idle", busy, 1'b0);
        chk("mask_count", ex_count, 16'd5);
        step();
        chk("mask_no_late_pulse", {wb_ex, busy}, 2'b00);

        // reset while redirect pending
        drive(v);
        redirect_ready = 1'b0;
        step(); clear_ev();
        step();
        chk("rst_in_redirect", redirect_valid, 1'b1);
        reset = 1'b1;
        step();
        chk("rst_abort", {redirect_valid, busy, pipe_flush, wb_ex, ertn_flush}, 5'b00000);
        chk("rst_count", ex_count, 16'd0);
        reset = 1'b0;
        redirect_ready = 1'b1;
        step();
        chk("rst_no_pulse", {wb_ex, ertn_flush, busy}, 3'b000);

        // five exceptions: 16-bit counter reaches 5, 2-bit counter sticks at 3
        for (int i = 0; i < 5; i++) begin
            v = mk(1'b1, 1'b0, 1'b1, 1'b0, 6'h09, 9'h000, 32'h1C00_1000 + 32'(i * 4), 32'h0, 32'h1C00_8000, 32'h1C00_0040,
                   1'b1, 1'b1, 6'h09, 9'h000, 32'h1C00_1000 + 32'(i * 4), 32'h0, 32'h1C00_8000, 16'(i + 1));
            run_vec(v, 10 + i);
            if (i == 2) chk("sat_reach", s_ex_count, 2'b11);
        end
        chk("sat_hold", s_ex_count, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
